// File: rtl/mc_ctrl_fsm_pkg.sv
// ---------------------------------------------------------------------------
// ctrl_encode_def
// Shared encodings for the multicycle MIPS control sequencer: control-field
// constants (extender mode, ALU op, ALU B source, PC source), the opcode and
// funct values the controller understands, the sequencer state enumeration,
// the packed control word, and the DECODE dispatch function used by both the
// next-state logic and the illegal-instruction detection.
// ---------------------------------------------------------------------------
package ctrl_encode_def;

   // Immediate extender modes
   localparam logic [1:0] EXTOP_ZERO   = 2'b00;
   localparam logic [1:0] EXTOP_SIGNED = 2'b01;
   localparam logic [1:0] EXTOP_INST   = 2'b10;

   // ALU operation selects
   localparam logic [1:0] ALUOP_ADD    = 2'b00;
   localparam logic [1:0] ALUOP_SUB    = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT  = 2'b10;
   localparam logic [1:0] ALUOP_OR     = 2'b11;

   // ALU B operand sources
   localparam logic [1:0] ALUSRCB_REG   = 2'b00;
   localparam logic [1:0] ALUSRCB_FOUR  = 2'b01;
   localparam logic [1:0] ALUSRCB_IMM   = 2'b10;
   localparam logic [1:0] ALUSRCB_IMMSH = 2'b11;

   // PC update sources
   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

   // Supported opcodes
   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_ADDIU = 6'b001001;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_ANDI  = 6'b001100;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;

   // Supported R-type functs
   localparam logic [5:0] FN_ADDU = 6'b100001;
   localparam logic [5:0] FN_SUBU = 6'b100011;
   localparam logic [5:0] FN_AND  = 6'b100100;
   localparam logic [5:0] FN_OR   = 6'b100101;
   localparam logic [5:0] FN_SLT  = 6'b101010;

   typedef enum logic [3:0] {
      ST_FETCH, ST_DECODE, ST_MEM_ADDR, ST_MEM_RD, ST_MEM_WB, ST_MEM_WR,
      ST_R_EXE, ST_R_WB, ST_I_EXE, ST_I_WB, ST_BRANCH, ST_JUMP
   } state_t;

   typedef struct packed {
      logic       memReq;
      logic       memWe;
      logic       iord;
      logic       irWrite;
      logic       mdrWrite;
      logic       pcWrite;
      logic [1:0] pcSrc;
      logic       aluSrcA;
      logic [1:0] aluSrcB;
      logic [1:0] aluOp;
      logic [1:0] extOp;
      logic       regDst;
      logic       memToReg;
      logic       regWrite;
      logic       illegal;
   } ctrl_word_t;

   // Where DECODE dispatches to; ST_FETCH means the instruction is unsupported
   function automatic state_t decodeTarget(input logic [5:0] opcode, input logic [5:0] funct);
      state_t target;
      target = ST_FETCH;
      case (opcode)
         OP_RTYPE: begin
            if (funct == FN_ADDU || funct == FN_SUBU || funct == FN_AND ||
                funct == FN_OR   || funct == FN_SLT)
               target = ST_R_EXE;
         end
         OP_LW, OP_SW:             target = ST_MEM_ADDR;
         OP_ADDIU, OP_ORI, OP_ANDI: target = ST_I_EXE;
         OP_BEQ:                   target = ST_BRANCH;
         OP_J:                     target = ST_JUMP;
         default:                  target = ST_FETCH;
      endcase
      return target;
   endfunction

endpackage

// File: rtl/mc_ctrl_fsm_if.sv
// ---------------------------------------------------------------------------
// mc_ctrl_fsm_if
// Bundle between the control sequencer and the datapath/memory.
//   Datapath -> controller: opcode, funct, zero, mem_ready
//   Controller -> datapath: memory handshake (mem_req, mem_we, iord),
//     register enables (ir_write, mdr_write, pc_write, reg_write), muxing
//     selects (pc_src, alu_src_a, alu_src_b, alu_op, ext_op, reg_dst,
//     mem_to_reg) and the error pulses (illegal, bus_err).
// master = the controller, slave = the datapath side.
// ---------------------------------------------------------------------------
interface mc_ctrl_fsm_if;
   logic [5:0] opcode;
   logic [5:0] funct;
   logic       zero;
   logic       mem_ready;
   logic       mem_req;
   logic       mem_we;
   logic       iord;
   logic       ir_write;
   logic       mdr_write;
   logic       pc_write;
   logic [1:0] pc_src;
   logic       alu_src_a;
   logic [1:0] alu_src_b;
   logic [1:0] alu_op;
   logic [1:0] ext_op;
   logic       reg_dst;
   logic       mem_to_reg;
   logic       reg_write;
   logic       illegal;
   logic       bus_err;

   modport master (
      input  opcode, funct, zero, mem_ready,
      output mem_req, mem_we, iord, ir_write, mdr_write, pc_write, pc_src,
             alu_src_a, alu_src_b, alu_op, ext_op, reg_dst, mem_to_reg,
             reg_write, illegal, bus_err
   );

   modport slave (
      output opcode, funct, zero, mem_ready,
      input  mem_req, mem_we, iord, ir_write, mdr_write, pc_write, pc_src,
             alu_src_a, alu_src_b, alu_op, ext_op, reg_dst, mem_to_reg,
             reg_write, illegal, bus_err
   );
endinterface

// File: rtl/mc_ctrl_fsm_decode.sv
// ---------------------------------------------------------------------------
// mc_ctrl_decode
// Pure combinational decoder from sequencer state (plus opcode/funct and the
// two same-cycle qualifiers zero and mem_ready) to the datapath control word.
//   state_i     current sequencer state
//   en_i        high when out of reset; low forces an all-zero control word
//   opcode_i    IR[31:26]
//   funct_i     IR[5:0]
//   zero_i      ALU zero flag (used in BRANCH)
//   memReady_i  memory completion (qualifies the FETCH/MEM_RD writes)
//   ctrl_o      control word
// ---------------------------------------------------------------------------
module mc_ctrl_decode
   import ctrl_encode_def::*;
(
   input  state_t     state_i,
   input  logic       en_i,
   input  logic [5:0] opcode_i,
   input  logic [5:0] funct_i,
   input  logic       zero_i,
   input  logic       memReady_i,
   output ctrl_word_t ctrl_o
);

   // Everything defaults to 0 (ext_op = ZERO); each state raises only what it
   // needs. The I-type extender mode is shared by I_EXE and I_WB so the
   // immediate stays stable through the writeback cycle.
   always_comb begin
      logic [1:0] iExt;
      ctrl_o = '0;
      iExt   = (opcode_i == OP_ADDIU) ? EXTOP_SIGNED : EXTOP_ZERO;
      if (en_i) begin
         case (state_i)
            ST_FETCH: begin
               ctrl_o.memReq  = 1'b1;
               ctrl_o.aluSrcB = ALUSRCB_FOUR;
               ctrl_o.aluOp   = ALUOP_ADD;
               ctrl_o.irWrite = memReady_i;
               ctrl_o.pcWrite = memReady_i;
               ctrl_o.pcSrc   = PCSRC_ALU;
            end
            ST_DECODE: begin
               ctrl_o.aluSrcB = ALUSRCB_IMMSH;
               ctrl_o.aluOp   = ALUOP_ADD;
               ctrl_o.extOp   = EXTOP_SIGNED;
               ctrl_o.illegal = (decodeTarget(opcode_i, funct_i) == ST_FETCH);
            end
            ST_MEM_ADDR: begin
               ctrl_o.aluSrcA = 1'b1;
               ctrl_o.aluSrcB = ALUSRCB_IMM;
               ctrl_o.extOp   = EXTOP_SIGNED;
               ctrl_o.aluOp   = ALUOP_ADD;
            end
            ST_MEM_RD: begin
               ctrl_o.memReq   = 1'b1;
               ctrl_o.iord     = 1'b1;
               ctrl_o.mdrWrite = memReady_i;
            end
            ST_MEM_WB: begin
               ctrl_o.regWrite = 1'b1;
               ctrl_o.memToReg = 1'b1;
            end
            ST_MEM_WR: begin
               ctrl_o.memReq = 1'b1;
               ctrl_o.memWe  = 1'b1;
               ctrl_o.iord   = 1'b1;
            end
            ST_R_EXE: begin
               ctrl_o.aluSrcA = 1'b1;
               ctrl_o.aluSrcB = ALUSRCB_REG;
               ctrl_o.aluOp   = ALUOP_FUNCT;
            end
            ST_R_WB: begin
               ctrl_o.regWrite = 1'b1;
               ctrl_o.regDst   = 1'b1;
            end
            ST_I_EXE: begin
               ctrl_o.aluSrcA = 1'b1;
               ctrl_o.aluSrcB = ALUSRCB_IMM;
               ctrl_o.extOp   = iExt;
               case (opcode_i)
                  OP_ORI:  ctrl_o.aluOp = ALUOP_OR;
                  OP_ANDI: ctrl_o.aluOp = ALUOP_FUNCT;
                  default: ctrl_o.aluOp = ALUOP_ADD;
               endcase
            end
            ST_I_WB: begin
               ctrl_o.regWrite = 1'b1;
               ctrl_o.extOp    = iExt;
            end
            ST_BRANCH: begin
               ctrl_o.aluSrcA = 1'b1;
               ctrl_o.aluSrcB = ALUSRCB_REG;
               ctrl_o.aluOp   = ALUOP_SUB;
               ctrl_o.pcSrc   = PCSRC_ALUOUT;
               ctrl_o.pcWrite = zero_i;
            end
            ST_JUMP: begin
               ctrl_o.extOp   = EXTOP_INST;
               ctrl_o.pcSrc   = PCSRC_JUMP;
               ctrl_o.pcWrite = 1'b1;
            end
            default: ctrl_o = '0;
         endcase
      end
   end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// ---------------------------------------------------------------------------
// mc_ctrl_fsm
// Multicycle control sequencer for the MIPS datapath. Steps each instruction
// through fetch/decode/execute/memory/writeback, owns the memory
// request/ready handshake and flags a bus error when memory does not answer
// within TIMEOUT cycles.
//   clk     system clock, rising edge
//   rst     synchronous reset, active-low
//   bus_io  controller side of mc_ctrl_fsm_if (see interface header)
// ---------------------------------------------------------------------------
module mc_ctrl_fsm
   import ctrl_encode_def::*;
#(
   parameter int TIMEOUT = 16,
   parameter int CNT_W   = 8
) (
   input  logic            clk,
   input  logic            rst,
   mc_ctrl_fsm_if.master   bus_io
);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] waitCnt_q, waitCnt_d;
   ctrl_word_t       ctrl;
   logic             waiting;
   logic             timeout;

   // Outputs are forced to zero while rst is low so no strobe escapes during
   // the reset cycle, whatever state the register held before it.
   mc_ctrl_decode uDecode (
      .state_i    (state_q),
      .en_i       (rst),
      .opcode_i   (bus_io.opcode),
      .funct_i    (bus_io.funct),
      .zero_i     (bus_io.zero),
      .memReady_i (bus_io.mem_ready),
      .ctrl_o     (ctrl)
   );

   assign waiting = ctrl.memReq & ~bus_io.mem_ready;
   assign timeout = waiting & (waitCnt_q == CNT_W'(TIMEOUT - 1));

   // Next-state: memory states hold until ready, or abandon to FETCH on timeout
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_FETCH: begin
            if (bus_io.mem_ready) state_d = ST_DECODE;
            else if (timeout)     state_d = ST_FETCH;
         end
         ST_DECODE:   state_d = decodeTarget(bus_io.opcode, bus_io.funct);
         ST_MEM_ADDR: state_d = (bus_io.opcode == OP_SW) ? ST_MEM_WR : ST_MEM_RD;
         ST_MEM_RD: begin
            if (bus_io.mem_ready) state_d = ST_MEM_WB;
            else if (timeout)     state_d = ST_FETCH;
         end
         ST_MEM_WR: begin
            if (bus_io.mem_ready || timeout) state_d = ST_FETCH;
         end
         ST_R_EXE: state_d = ST_R_WB;
         ST_I_EXE: state_d = ST_I_WB;
         default:  state_d = ST_FETCH;
      endcase
   end

   // Wait counter restarts on any state change and after a timeout (a FETCH
   // timeout stays in FETCH, so it would not otherwise be cleared).
   always_comb begin
      waitCnt_d = waitCnt_q;
      if (state_d != state_q || timeout)
         waitCnt_d = '0;
      else if (waiting)
         waitCnt_d = waitCnt_q + CNT_W'(1);
   end

   // State register and wait counter, synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q   <= ST_FETCH;
         waitCnt_q <= '0;
      end else begin
         state_q   <= state_d;
         waitCnt_q <= waitCnt_d;
      end
   end

   assign bus_io.mem_req    = ctrl.memReq;
   assign bus_io.mem_we     = ctrl.memWe;
   assign bus_io.iord       = ctrl.iord;
   assign bus_io.ir_write   = ctrl.irWrite;
   assign bus_io.mdr_write  = ctrl.mdrWrite;
   assign bus_io.pc_write   = ctrl.pcWrite;
   assign bus_io.pc_src     = ctrl.pcSrc;
   assign bus_io.alu_src_a  = ctrl.aluSrcA;
   assign bus_io.alu_src_b  = ctrl.aluSrcB;
   assign bus_io.alu_op     = ctrl.aluOp;
   assign bus_io.ext_op     = ctrl.extOp;
   assign bus_io.reg_dst    = ctrl.regDst;
   assign bus_io.mem_to_reg = ctrl.memToReg;
   assign bus_io.reg_write  = ctrl.regWrite;
   assign bus_io.illegal    = ctrl.illegal;
   assign bus_io.bus_err    = timeout;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// ---------------------------------------------------------------------------
// tb_mc_ctrl_fsm
// Directed bench for the multicycle control sequencer. Each task starts in
// the middle of a FETCH cycle and walks one or more instructions, checking
// the control outputs of every state against hand-derived values.
// ---------------------------------------------------------------------------
module tb_mc_ctrl_fsm;

   logic clk;
   logic rst;
   int   tests;
   int   failed;

   mc_ctrl_fsm_if bus ();

   mc_ctrl_fsm #(.TIMEOUT(16), .CNT_W(8)) dut (
      .clk    (clk),
      .rst    (rst),
      .bus_io (bus)
   );

   // 10 ns clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Advance to just after the next rising edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Apply opcode/mem_ready and let combinational outputs settle
   task automatic applyStimulus(input logic [5:0] op, input logic rdy);
      bus.opcode    = op;
      bus.mem_ready = rdy;
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      bus.mem_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         tests++; if ({bus.mem_req, bus.ir_write, bus.pc_write, bus.reg_write, bus.mdr_write} !== 5'b00000) begin failed++; $display("[TB] FAIL reset_strobes cycle %0d got %b exp 00000", i, {bus.mem_req, bus.ir_write, bus.pc_write, bus.reg_write, bus.mdr_write}); end
         tests++; if (bus.ext_op !== 2'b00) begin failed++; $display("[TB] FAIL reset_ext_op got %b exp 00", bus.ext_op); end
      end
      rst = 1'b1;
      #1;
      tests++; if ({bus.mem_req, bus.ir_write, bus.pc_write} !== 3'b111) begin failed++; $display("[TB] FAIL reset_fetch req/ir/pc got %b exp 111", {bus.mem_req, bus.ir_write, bus.pc_write}); end
      tests++; if ({bus.iord, bus.alu_src_a, bus.alu_src_b, bus.alu_op, bus.pc_src} !== 8'b00_01_00_00) begin failed++; $display("[TB] FAIL reset_fetch selects got %b exp 00010000", {bus.iord, bus.alu_src_a, bus.alu_src_b, bus.alu_op, bus.pc_src}); end
   endtask

   task automatic test_addiu();
      applyStimulus(6'b001001, 1'b1);
      tests++; if (bus.reg_write !== 1'b0) begin failed++; $display("[TB] FAIL addiu_fetch reg_write got %b exp 0", bus.reg_write); end
      tick();
      applyStimulus(6'b001001, 1'b0);
      tests++; if ({bus.alu_src_a, bus.alu_src_b, bus.alu_op, bus.ext_op, bus.illegal, bus.mem_req} !== 9'b0_11_00_01_0_0) begin failed++; $display("[TB] FAIL addiu_decode got %b exp 011000100", {bus.alu_src_a, bus.alu_src_b, bus.alu_op, bus.ext_op, bus.illegal, bus.mem_req}); end
      tick();
      applyStimulus(6'b001001, 1'b0);
      tests++; if ({bus.alu_src_a, bus.alu_src_b, bus.alu_op, bus.ext_op, bus.reg_write} !== 8'b1_10_00_01_0) begin failed++; $display("[TB] FAIL addiu_iexe got %b exp 11000010", {bus.alu_src_a, bus.alu_src_b, bus.alu_op, bus.ext_op, bus.reg_write}); end
      tick();
      applyStimulus(6'b001001, 1'b0);
      tests++; if ({bus.reg_write, bus.reg_dst, bus.mem_to_reg, bus.ext_op} !== 5'b1_0_0_01) begin failed++; $display("[TB] FAIL addiu_iwb got %b exp 10001", {bus.reg_write, bus.reg_dst, bus.mem_to_reg, bus.ext_op}); end
      tick();
   endtask

   task automatic test_ori_lw();
      int reqCycles;
      int mdrPulses;
      applyStimulus(6'b001101, 1'b1);
      tick();
      applyStimulus(6'b001101, 1'b0);
      tick();
      tests++; if ({bus.ext_op, bus.alu_op, bus.alu_src_b} !== 6'b00_11_10) begin failed++; $display("[TB] FAIL ori_iexe ext/alu_op/srcb got %b exp 001110", {bus.ext_op, bus.alu_op, bus.alu_src_b}); end
      tick();
      tests++; if ({bus.reg_write, bus.ext_op} !== 3'b1_00) begin failed++; $display("[TB] FAIL ori_iwb got %b exp 100", {bus.reg_write, bus.ext_op}); end
      tick();
      // lw: fetch, decode, mem_addr, then MEM_RD with ready held off 3 cycles
      applyStimulus(6'b100011, 1'b1);
      tick();
      applyStimulus(6'b100011, 1'b0);
      tick();
      tests++; if ({bus.alu_src_a, bus.alu_src_b, bus.ext_op, bus.alu_op, bus.mem_req} !== 8'b1_10_01_00_0) begin failed++; $display("[TB] FAIL lw_memaddr got %b exp 11001000", {bus.alu_src_a, bus.alu_src_b, bus.ext_op, bus.alu_op, bus.mem_req}); end
      tick();
      reqCycles = 0;
      mdrPulses = 0;
      for (int i = 0; i < 4; i++) begin
         applyStimulus(6'b100011, (i == 3));
         if (bus.mem_req === 1'b1 && bus.iord === 1'b1 && bus.mem_we === 1'b0) reqCycles++;
         if (bus.mdr_write === 1'b1) mdrPulses++;
         tick();
      end
      tests++; if (reqCycles !== 4) begin failed++; $display("[TB] FAIL lw_memrd req_cycles got %0d exp 4", reqCycles); end
      tests++; if (mdrPulses !== 1) begin failed++; $display("[TB] FAIL lw_memrd mdr_pulses got %0d exp 1", mdrPulses); end
      // mem_ready high here must be ignored (no request outstanding)
      applyStimulus(6'b100011, 1'b1);
      tests++; if ({bus.reg_write, bus.mem_to_reg, bus.reg_dst, bus.mem_req, bus.mdr_write} !== 5'b11000) begin failed++; $display("[TB] FAIL lw_memwb got %b exp 11000", {bus.reg_write, bus.mem_to_reg, bus.reg_dst, bus.mem_req, bus.mdr_write}); end
      tick();
      applyStimulus(6'b100011, 1'b0);
      tests++; if ({bus.mem_req, bus.iord} !== 2'b10) begin failed++; $display("[TB] FAIL lw_back_to_fetch req/iord got %b exp 10", {bus.mem_req, bus.iord}); end
   endtask

   task automatic test_branch_jump();
      for (int k = 0; k < 2; k++) begin
         bus.zero = (k == 0);
         applyStimulus(6'b000100, 1'b1);
         tick();
         applyStimulus(6'b000100, 1'b0);
         tick();
         tests++; if ({bus.pc_write, bus.pc_src, bus.alu_op, bus.alu_src_a, bus.alu_src_b} !== {(k == 0), 7'b01_01_1_00}) begin failed++; $display("[TB] FAIL beq_branch zero=%0d got %b exp %b", bus.zero, {bus.pc_write, bus.pc_src, bus.alu_op, bus.alu_src_a, bus.alu_src_b}, {(k == 0), 7'b01_01_1_00}); end
         tick();
      end
      bus.zero = 1'b0;
      applyStimulus(6'b000010, 1'b1);
      tick();
      applyStimulus(6'b000010, 1'b0);
      tick();
      tests++; if ({bus.ext_op, bus.pc_src, bus.pc_write, bus.mem_req} !== 6'b10_10_1_0) begin failed++; $display("[TB] FAIL j_jump got %b exp 101010", {bus.ext_op, bus.pc_src, bus.pc_write, bus.mem_req}); end
      tick();
      applyStimulus(6'b000010, 1'b0);
      tests++; if ({bus.mem_req, bus.alu_src_b} !== 3'b1_01) begin failed++; $display("[TB] FAIL j_back_to_fetch got %b exp 101", {bus.mem_req, bus.alu_src_b}); end
   endtask

   task automatic test_illegal();
      // Unknown opcode, then R-type with unsupported funct, then legal addu
      for (int k = 0; k < 3; k++) begin
         bus.funct = (k == 2) ? 6'b100001 : 6'b000000;
         applyStimulus((k == 0) ? 6'b111111 : 6'b000000, 1'b1);
         tick();
         applyStimulus((k == 0) ? 6'b111111 : 6'b000000, 1'b0);
         tests++; if ({bus.illegal, bus.reg_write} !== {(k != 2), 1'b0}) begin failed++; $display("[TB] FAIL illegal_decode case %0d got %b exp %b", k, {bus.illegal, bus.reg_write}, {(k != 2), 1'b0}); end
         tick();
         if (k == 2) begin
            tests++; if ({bus.alu_src_a, bus.alu_src_b, bus.alu_op, bus.illegal} !== 6'b1_00_10_0) begin failed++; $display("[TB] FAIL addu_rexe got %b exp 100100", {bus.alu_src_a, bus.alu_src_b, bus.alu_op, bus.illegal}); end
            tick();
            tests++; if ({bus.reg_write, bus.reg_dst, bus.mem_to_reg} !== 3'b110) begin failed++; $display("[TB] FAIL addu_rwb got %b exp 110", {bus.reg_write, bus.reg_dst, bus.mem_to_reg}); end
            tick();
         end
         applyStimulus(6'b000000, 1'b0);
         tests++; if ({bus.mem_req, bus.illegal, bus.reg_write} !== 3'b100) begin failed++; $display("[TB] FAIL illegal_next_fetch case %0d got %b exp 100", k, {bus.mem_req, bus.illegal, bus.reg_write}); end
      end
   endtask

   task automatic test_timeout_reset();
      int errPulses;
      int errAt;
      int badWrites;
      bus.funct = 6'b000000;
      applyStimulus(6'b101011, 1'b1);
      tick();
      applyStimulus(6'b101011, 1'b0);
      tick();
      tick();
      errPulses = 0;
      errAt     = -1;
      badWrites = 0;
      for (int i = 0; i < 16; i++) begin
         applyStimulus(6'b101011, 1'b0);
         if (bus.bus_err === 1'b1) begin errPulses++; errAt = i; end
         if ({bus.mem_req, bus.mem_we, bus.iord} !== 3'b111) badWrites++;
         if ({bus.ir_write, bus.pc_write, bus.reg_write, bus.mdr_write} !== 4'b0000) badWrites++;
         tick();
      end
      tests++; if (errPulses !== 1) begin failed++; $display("[TB] FAIL sw_timeout pulses got %0d exp 1", errPulses); end
      tests++; if (errAt !== 15) begin failed++; $display("[TB] FAIL sw_timeout cycle got %0d exp 15", errAt); end
      tests++; if (badWrites !== 0) begin failed++; $display("[TB] FAIL sw_wait outputs bad_cycles got %0d exp 0", badWrites); end
      applyStimulus(6'b101011, 1'b0);
      tests++; if ({bus.mem_req, bus.mem_we, bus.iord, bus.bus_err} !== 4'b1000) begin failed++; $display("[TB] FAIL sw_timeout_fetch got %b exp 1000", {bus.mem_req, bus.mem_we, bus.iord, bus.bus_err}); end
      // Second sw, reset while waiting in MEM_WR
      applyStimulus(6'b101011, 1'b1);
      tick();
      applyStimulus(6'b101011, 1'b0);
      tick();
      tick();
      for (int i = 0; i < 3; i++) tick();
      tests++; if ({bus.mem_req, bus.mem_we} !== 2'b11) begin failed++; $display("[TB] FAIL sw_wait_before_rst got %b exp 11", {bus.mem_req, bus.mem_we}); end
      rst = 1'b0;
      tick();
      tests++; if ({bus.mem_req, bus.mem_we, bus.bus_err} !== 3'b000) begin failed++; $display("[TB] FAIL rst_mid_wait got %b exp 000", {bus.mem_req, bus.mem_we, bus.bus_err}); end
      rst = 1'b1;
      #1;
      tests++; if ({bus.mem_req, bus.mem_we, bus.iord} !== 3'b100) begin failed++; $display("[TB] FAIL rst_release_fetch got %b exp 100", {bus.mem_req, bus.mem_we, bus.iord}); end
   endtask

   initial begin
      tests         = 0;
      failed        = 0;
      rst           = 1'b0;
      bus.opcode    = 6'b000000;
      bus.funct     = 6'b000000;
      bus.zero      = 1'b0;
      bus.mem_ready = 1'b0;
      test_reset();
      test_addiu();
      test_ori_lw();
      test_branch_jump();
      test_illegal();
      test_timeout_reset();
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

   // Global time bound
   initial begin
      #200000;
      $display("[TB] FAIL watchdog expired got timeout exp completion");
      $fatal(1, "[TB] watchdog");
   end

endmodule

// File: doc/mc_ctrl_fsm.md
Name: mc_ctrl_fsm

Overview:
- Multicycle control sequencer for the MIPS datapath.
- Steps each instruction through fetch/decode/execute/memory/writeback and drives all datapath enables.
- Drives the immediate-extender mode (ext_op), ALU source and operation selects, and PC update.
- Owns the memory request/ready handshake, with a timeout.
- Sits between the instruction register (IR) and the datapath; replaces the single-cycle combinational control.

Parameters:
- TIMEOUT, 16, maximum cycles to wait for mem_ready before flagging bus_err (range 2..255).
- CNT_W, 8, width of the wait counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous reset, active-low (asserted when 0, sampled on the rising clk edge).
- opcode  in  6  IR[31:26]; stable from the cycle after ir_write.
- funct  in  6  IR[5:0].
- zero  in  1  ALU zero flag, valid in BRANCH.
- mem_ready  in  1  memory has completed the current request.
- mem_req  out  1  memory request, held until mem_ready.
- mem_we  out  1  1=write, 0=read; qualified by mem_req.
- iord  out  1  address source: 0=PC, 1=ALUOut.
- ir_write  out  1  load IR.
- mdr_write  out  1  load memory data register.
- pc_write  out  1  load PC.
- pc_src  out  2  00=ALU, 01=ALUOut, 10=jump target.
- alu_src_a  out  1  0=PC, 1=reg A.
- alu_src_b  out  2  00=reg B, 01=const 4, 10=ext imm, 11=ext imm<<2.
- alu_op  out  2  00=ADD, 01=SUB, 10=use funct, 11=OR.
- ext_op  out  2  extender mode: ZERO=2'b00, SIGNED=2'b01, INST=2'b10.
- reg_dst  out  1  0=rt, 1=rd.
- mem_to_reg  out  1  0=ALUOut, 1=MDR.
- reg_write  out  1  register file write enable.
- illegal  out  1  one-cycle pulse on an unsupported opcode or funct.
- bus_err  out  1  one-cycle pulse on memory timeout.

Behaviour:
- States: FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, R_EXE, R_WB, I_EXE, I_WB, BRANCH, JUMP.
- Reset (rst=0 at a clk edge):
  - state becomes FETCH and the wait counter becomes 0.
  - All outputs are combinational from state, so every strobe is 0 in the reset cycle.
  - ext_op=ZERO in the reset cycle.
  - Reset mid-operation aborts any pending handshake with no write issued.
- All outputs are decoded from state and opcode. Every unlisted output is 0 and ext_op is ZERO.
- FETCH:
  - mem_req=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=ADD.
  - On mem_ready: ir_write=1, pc_write=1, pc_src=00, then go to DECODE.
  - Otherwise stay in FETCH.
- DECODE:
  - alu_src_a=0, alu_src_b=11, alu_op=ADD, ext_op=SIGNED (precomputes the branch target).
  - Next state by opcode:
    - 000000 goes to R_EXE if funct is in {100001 addu, 100011 subu, 100100 and, 100101 or, 101010 slt}.
    - 100011 (lw) and 101011 (sw) go to MEM_ADDR.
    - 001001 (addiu), 001101 (ori), 001100 (andi) go to I_EXE.
    - 000100 (beq) goes to BRANCH.
    - 000010 (j) goes to JUMP.
    - Anything else: illegal=1 for this cycle, then FETCH. PC has already advanced by 4.
- MEM_ADDR: alu_src_a=1, alu_src_b=10, ext_op=SIGNED, alu_op=ADD. Next is MEM_RD for lw, MEM_WR for sw.
- MEM_RD:
  - mem_req=1, iord=1, mem_we=0.
  - On mem_ready: mdr_write=1, then go to MEM_WB.
- MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=0, then FETCH.
- MEM_WR: mem_req=1, mem_we=1, iord=1. On mem_ready go to FETCH.
- R_EXE: alu_src_a=1, alu_src_b=00, alu_op=10, then R_WB.
- R_WB: reg_write=1, reg_dst=1, mem_to_reg=0, then FETCH.
- I_EXE:
  - alu_src_a=1, alu_src_b=10.
  - addiu: ext_op=SIGNED, alu_op=ADD.
  - ori: ext_op=ZERO, alu_op=OR.
  - andi: ext_op=ZERO, alu_op=10 (datapath maps it via the funct override; this block asserts funct-independent AND through alu_op=10 only when opcode=001100).
  - Then I_WB.
- I_WB: reg_write=1, reg_dst=0, mem_to_reg=0. ext_op is held at the I_EXE value. Then FETCH.
- BRANCH:
  - alu_src_a=1, alu_src_b=00, alu_op=SUB, pc_src=01.
  - pc_write=zero (combinational, same cycle). Then FETCH.
- JUMP: ext_op=INST, pc_src=10, pc_write=1, then FETCH.
- Memory handshake and timeout:
  - mem_req stays high and all other outputs stay stable until mem_ready.
  - mem_ready sampled high ends the request in that same cycle.
  - The wait counter increments every cycle mem_req=1 and mem_ready=0, and clears on state change.
  - When the counter reaches TIMEOUT-1 without mem_ready: bus_err=1 for one cycle, next state FETCH, no ir/mdr/pc/reg write.
  - mem_ready while mem_req=0 is ignored.
- Every instruction takes at least 3 cycles:
  - j, beq: 3.
  - R-type, I-type, sw: 4.
  - lw: 5.
  - Each memory state adds (ready wait) cycles.

Decomposition:
- Shared package (ctrl_encode_def): EXTOP_ZERO/SIGNED/INST, ALUOP_*, ALUSRCB_*, PCSRC_* constants, opcode/funct constants, and the state enumeration.
- One sub-module, mc_ctrl_decode: pure combinational state+opcode to control-word decoder.
- Top level keeps the state register, next-state logic and wait counter.

Test Plan:
- Reset held 0 for 3 cycles then released, mem_ready=1 -> all strobes 0 during reset; FETCH asserts mem_req=1, ir_write=1, pc_write=1 on the first active cycle.
- addiu (opcode 001001), mem_ready=1 -> FETCH, DECODE, I_EXE, I_WB. ext_op=01 in I_EXE/I_WB. reg_write=1 only in cycle 4, with reg_dst=0.
- ori (001101) -> ext_op=00, alu_op=11 in I_EXE. Then lw with mem_ready delayed 3 cycles -> mem_req held 4 cycles in MEM_RD, mdr_write pulses once, reg_write in MEM_WB with mem_to_reg=1.
- beq with zero=1 then zero=0 -> pc_write=1 with pc_src=01 in the BRANCH cycle for the first, pc_write=0 for the second. j -> ext_op=10, pc_src=10, pc_write=1.
- Opcode 111111 -> illegal pulses 1 cycle in DECODE, next state FETCH, no reg_write. R-type funct 000000 -> same.
- sw with mem_ready stuck 0, TIMEOUT=16 -> bus_err pulses exactly once after 16 cycles in MEM_WR, then FETCH. rst=0 mid-wait -> mem_req drops the next cycle.
